palette_lut_fader: RTL and testbench
====================================

Name: palette_lut_fader

Overview:
- Parametrised successor to the fixed 16-entry grey sprite palettes.
- Holds NUM_PALETTES run-time-writable colour banks, each with 2^INDEX_W RGB entries, reset-initialised to a grey ramp.
- Adds a transparency flag and a frame-paced global fade (brightness) engine with a 2-cycle registered pixel pipeline.
- Sits between the sprite ROM index output and the VGA colour mux; a single instance serves all sprites through bank select.

Parameters:
- INDEX_W, 4, palette index width; entries per bank = 2^INDEX_W.
- CH_W, 4, bits per colour channel.
- NUM_PALETTES, 4, number of banks; must be ≥2. BANK_W = $clog2(NUM_PALETTES).
- LEVEL_W, 4, fade level width; level range 0..2^LEVEL_W-1.
- FADE_STEP, 1, level change per frame_tick while fading.
- TRANSPARENT_IDX, 0, index value flagged as transparent.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel lookup request this cycle.
- index  in  INDEX_W  pixel palette index.
- bank  in  BANK_W  palette bank used for the lookup.
- wr_en  in  1  palette entry write strobe.
- wr_bank  in  BANK_W  bank to write.
- wr_index  in  INDEX_W  entry to write.
- wr_rgb  in  3*CH_W  {red, green, blue} data to write.
- frame_tick  in  1  one-cycle pulse per frame (vsync edge).
- fade_out_req  in  1  pulse: start fading toward black.
- fade_in_req  in  1  pulse: start fading toward full brightness.
- red, green, blue  out  CH_W each  scaled colour.
- out_valid  out  1  red/green/blue/out_transparent valid this cycle.
- out_transparent  out  1  looked-up index equalled TRANSPARENT_IDX.
- fade_level  out  LEVEL_W  current brightness level.
- fade_busy  out  1  high while in FADING_OUT or FADING_IN.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - Every entry i of every bank = grey: each channel = i[INDEX_W-1 -: CH_W] if INDEX_W≥CH_W, else i << (CH_W-INDEX_W).
  - red/green/blue/out_valid/out_transparent = 0.
  - fade_level = 2^LEVEL_W-1; FSM state = FULL.
- Pipeline, fixed 2-cycle latency:
  - Stage 1 registers the entry at {bank, index}, in_valid, and (index==TRANSPARENT_IDX).
  - Stage 2 registers each channel = (c*(L+1)) >> LEVEL_W, where L is fade_level sampled in the same cycle as stage 2. Use (CH_W+LEVEL_W+1)-bit intermediates with no overflow; L=max gives exactly c, L=0 gives c>>LEVEL_W.
  - out_valid follows in_valid by 2 cycles. Outputs hold their last values while out_valid=0; there is no back-pressure.
- Writes:
  - Take effect on the clock edge with wr_en=1.
  - A same-cycle read of the same {bank, index} returns the old value (read-first); the next cycle's read returns the new value.
  - Writes are independent of in_valid and of the fade state.
- Fade FSM states: FULL, FADING_OUT, DARK, FADING_IN.
  - fade_out_req in FULL or FADING_IN → FADING_OUT.
  - fade_in_req in DARK or FADING_OUT → FADING_IN.
  - A request that already matches the current direction or terminal state is ignored.
  - fade_in_req and fade_out_req in the same cycle: fade_in_req wins.
  - A request and a frame_tick in the same cycle: the state changes, and the level does not move that cycle.
  - frame_tick in FADING_OUT: level -= FADE_STEP, saturating at 0; on reaching 0 go to DARK.
  - frame_tick in FADING_IN: level += FADE_STEP, saturating at max; on reaching max go to FULL.
  - frame_tick in FULL or DARK: no effect.
  - fade_busy = (state==FADING_OUT || state==FADING_IN).
- Reset asserted mid-fade or mid-pipeline: everything returns to reset values immediately, and in-flight pixels are discarded.

Test Plan:
- Reset, then in_valid=1, bank=2, index=9 → 2 cycles later red=green=blue=9, out_valid=1, out_transparent=0.
- index=0 with in_valid=1 → out_transparent=1 and rgb=0 two cycles later; in_valid=0 → out_valid=0 two cycles later, rgb held.
- Write bank 1 idx 5 = 12'hF30 while reading bank 1 idx 5 in the same cycle → that read returns 5,5,5. The next-cycle read returns F,3,0. Bank 0 idx 5 still returns 5,5,5.
- fade_out_req, then 15 frame_ticks → fade_level steps 15→0, fade_busy=1 until DARK, then 0. Reading entry F,3,0 at level 0 → red=0, green=0, blue=0; at level 7 → 7,1,0.
- At level 6 in FADING_OUT, assert fade_in_req and frame_tick together → state FADING_IN, level stays 6; next tick → level 7.
- Assert Reset_n=0 mid-fade at level 3 → fade_level=15 and out_valid=0 immediately, palette reverts to the grey ramp.

Source files
------------

// File: rtl/palette_lut_fader.sv
// Multi-bank palette lookup with a transparency flag and a frame-paced global fade.
// Pixels pass through a fixed two-stage registered pipeline; palette writes are read-first.
module palette_lut_fader #(
  parameter int INDEX_W         = 4,
  parameter int CH_W            = 4,
  parameter int NUM_PALETTES    = 4,
  parameter int LEVEL_W         = 4,
  parameter int FADE_STEP       = 1,
  parameter int TRANSPARENT_IDX = 0,
  localparam int BANK_W         = $clog2(NUM_PALETTES),
  localparam int RGB_W          = 3 * CH_W
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               in_valid,
  input  logic [INDEX_W-1:0] index,
  input  logic [BANK_W-1:0]  bank,
  input  logic               wr_en,
  input  logic [BANK_W-1:0]  wr_bank,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [RGB_W-1:0]   wr_rgb,
  input  logic               frame_tick,
  input  logic               fade_out_req,
  input  logic               fade_in_req,
  output logic [CH_W-1:0]    red,
  output logic [CH_W-1:0]    green,
  output logic [CH_W-1:0]    blue,
  output logic               out_valid,
  output logic               out_transparent,
  output logic [LEVEL_W-1:0] fade_level,
  output logic               fade_busy
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int PROD_W  = CH_W + LEVEL_W + 1;
  localparam logic [LEVEL_W-1:0] LVL_MAX = '1;
  localparam logic [LEVEL_W:0]   STEP    = (LEVEL_W + 1)'(FADE_STEP);

  typedef enum logic [1:0] {S_FULL, S_FADING_OUT, S_DARK, S_FADING_IN} state_t;

  logic [RGB_W-1:0]   r_pal [NUM_PALETTES][ENTRIES];
  logic [RGB_W-1:0]   r_rgb_p1;
  logic               r_vld_p1;
  logic               r_tr_p1;
  logic [CH_W-1:0]    r_red_p2;
  logic [CH_W-1:0]    r_green_p2;
  logic [CH_W-1:0]    r_blue_p2;
  logic               r_vld_p2;
  logic               r_tr_p2;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] w_level_nxt;
  logic               w_go_in;
  logic               w_go_out;

  // Top CH_W bits of the index, zero-padded below when the index is narrower.
  function automatic logic [CH_W-1:0] grey(input logic [INDEX_W-1:0] i);
    logic [INDEX_W+CH_W-1:0] t;
    t    = {i, {CH_W{1'b0}}};
    grey = t[INDEX_W+CH_W-1 -: CH_W];
  endfunction

  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                            input logic [LEVEL_W-1:0] l);
    logic [PROD_W-1:0] prod;
    prod  = PROD_W'(c) * PROD_W'(l) + PROD_W'(c);
    scale = CH_W'(prod >> LEVEL_W);
  endfunction

  function automatic logic [LEVEL_W-1:0] lvl_dec(input logic [LEVEL_W-1:0] l);
    if ({1'b0, l} <= STEP) lvl_dec = '0;
    else                   lvl_dec = LEVEL_W'({1'b0, l} - STEP);
  endfunction

  function automatic logic [LEVEL_W-1:0] lvl_inc(input logic [LEVEL_W-1:0] l);
    logic [LEVEL_W+1:0] s;
    s = {2'b00, l} + {1'b0, STEP};
    if (s >= {2'b00, LVL_MAX}) lvl_inc = LVL_MAX;
    else                       lvl_inc = LEVEL_W'(s);
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_PALETTES; b++)
        for (int e = 0; e < ENTRIES; e++)
          r_pal[BANK_W'(b)][INDEX_W'(e)] <= {3{grey(INDEX_W'(e))}};
    end else if (wr_en) begin
      r_pal[wr_bank][wr_index] <= wr_rgb;
    end
  end

  // Stage 1: palette read and transparency decode
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vld_p1 <= 1'b0;
      r_tr_p1  <= 1'b0;
      r_rgb_p1 <= '0;
    end else begin
      r_vld_p1 <= in_valid;
      r_tr_p1  <= (index == INDEX_W'(TRANSPARENT_IDX));
      r_rgb_p1 <= r_pal[bank][index];
    end
  end

  // Stage 2: brightness scaling; colour holds while no pixel is in flight
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vld_p2   <= 1'b0;
      r_tr_p2    <= 1'b0;
      r_red_p2   <= '0;
      r_green_p2 <= '0;
      r_blue_p2  <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_tr_p2    <= r_tr_p1;
        r_red_p2   <= scale(r_rgb_p1[RGB_W-1 -: CH_W], r_level);
        r_green_p2 <= scale(r_rgb_p1[2*CH_W-1 -: CH_W], r_level);
        r_blue_p2  <= scale(r_rgb_p1[CH_W-1:0], r_level);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_FULL;
      r_level <= LVL_MAX;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
    end
  end

  // A direction change takes the cycle; the level only moves on a tick with no change.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_go_in     = fade_in_req && (r_state == S_DARK || r_state == S_FADING_OUT);
    w_go_out    = fade_out_req && !fade_in_req &&
                  (r_state == S_FULL || r_state == S_FADING_IN);
    if (w_go_in) begin
      w_state_nxt = S_FADING_IN;
    end else if (w_go_out) begin
      w_state_nxt = S_FADING_OUT;
    end else if (frame_tick) begin
      case (r_state)
        S_FADING_OUT: begin
          w_level_nxt = lvl_dec(r_level);
          if (w_level_nxt == '0) w_state_nxt = S_DARK;
        end
        S_FADING_IN: begin
          w_level_nxt = lvl_inc(r_level);
          if (w_level_nxt == LVL_MAX) w_state_nxt = S_FULL;
        end
        default: ;
      endcase
    end
  end

  assign red             = r_red_p2;
  assign green           = r_green_p2;
  assign blue            = r_blue_p2;
  assign out_valid       = r_vld_p2;
  assign out_transparent = r_tr_p2;
  assign fade_level      = r_level;
  assign fade_busy       = (r_state == S_FADING_OUT) || (r_state == S_FADING_IN);

endmodule

// File: tb/tb_palette_lut_fader.sv
// Bench for palette_lut_fader: directed scenarios plus randomized traffic, all checked
// against a behavioural model of palettes, pixel latency and fade direction.
module tb_palette_lut_fader;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  index = '0;
  logic [1:0]  bank = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = '0;
  logic [3:0]  wr_index = '0;
  logic [11:0] wr_rgb = '0;
  logic        frame_tick = 1'b0;
  logic        fade_out_req = 1'b0;
  logic        fade_in_req = 1'b0;
  logic [3:0]  red, green, blue;
  logic        out_valid, out_transparent;
  logic [3:0]  fade_level;
  logic        fade_busy;
  logic [18:0] obs;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [11:0] mpal [4][16];
  logic        m_v1, m_t1;
  logic [11:0] m_e1;
  logic [3:0]  m_r, m_g, m_b;
  logic        m_ov, m_t;
  int          lvl;
  int          dir;   // +1 brightening, -1 darkening, 0 resting

  always #5 Clk = ~Clk;

  palette_lut_fader dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .index(index), .bank(bank),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .frame_tick(frame_tick), .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid),
    .out_transparent(out_transparent), .fade_level(fade_level), .fade_busy(fade_busy)
  );

  assign obs = {red, green, blue, out_valid, out_transparent, fade_level, fade_busy};

  function automatic logic [3:0] sc(input logic [3:0] c, input int l);
    return 4'((int'(c) * (l + 1)) / 16);
  endfunction

  function automatic logic [18:0] m_vec();
    return {m_r, m_g, m_b, m_ov, m_t, 4'(lvl), (dir != 0)};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 16; i++)
        mpal[b][i] = {3{4'(i)}};
    m_v1 = 0; m_t1 = 0; m_e1 = '0;
    m_r = '0; m_g = '0; m_b = '0; m_ov = 0; m_t = 0;
    lvl = 15; dir = 0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; index = '0; bank = '0; wr_en = 0; wr_bank = '0; wr_index = '0;
    wr_rgb = '0; frame_tick = 0; fade_out_req = 0; fade_in_req = 0;
  endtask

  // One clock: model advances using the inputs present at the rising edge.
  task automatic tick();
    @(posedge Clk);
    if (m_v1) begin
      m_r = sc(m_e1[11:8], lvl);
      m_g = sc(m_e1[7:4], lvl);
      m_b = sc(m_e1[3:0], lvl);
      m_t = m_t1;
    end
    m_ov = m_v1;
    m_v1 = in_valid;
    m_e1 = mpal[bank][index];
    m_t1 = (index == 4'd0);
    if (wr_en) mpal[wr_bank][wr_index] = wr_rgb;
    if (fade_in_req && (dir < 0 || (dir == 0 && lvl == 0))) dir = 1;
    else if (!fade_in_req && fade_out_req && (dir > 0 || (dir == 0 && lvl == 15))) dir = -1;
    else if (frame_tick && dir != 0) begin
      lvl = lvl + dir;
      if (lvl <= 0)  begin lvl = 0;  dir = 0; end
      if (lvl >= 15) begin lvl = 15; dir = 0; end
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 Reset_n = 0;
    model_reset();
    #11;
    tests++;
    if (obs !== {12'h000, 1'b0, 1'b0, 4'hF, 1'b0}) begin
      fails++; $display("FAIL reset_state: got %h expected %h", obs, {12'h000, 1'b0, 1'b0, 4'hF, 1'b0});
    end
    @(negedge Clk);
    Reset_n = 1;
    tick();
    tests++;
    if (obs !== m_vec()) begin
      fails++; $display("FAIL reset_release: got %h expected %h", obs, m_vec());
    end
  endtask

  task automatic test_grey();
    in_valid = 1; bank = 2'd2; index = 4'd9;
    tick();
    in_valid = 0;
    tick();
    tests++;
    if ({red, green, blue, out_valid, out_transparent} !== {12'h999, 1'b1, 1'b0}) begin
      fails++; $display("FAIL grey_b2_i9: got %h/%b%b expected 999/10", {red, green, blue}, out_valid, out_transparent);
    end
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16); bank = 2'(i); index = 4'(i);
      tick();
      tests++;
      if (obs !== m_vec()) begin
        fails++; $display("FAIL grey_ramp[%0d]: got %h expected %h", i, obs, m_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_transparent();
    in_valid = 1; bank = 2'd3; index = 4'd0;
    tick();
    index = 4'd7;
    tick();
    in_valid = 0;
    tests++;
    if ({red, green, blue, out_valid, out_transparent} !== {12'h000, 1'b1, 1'b1}) begin
      fails++; $display("FAIL transparent_idx0: got %h/%b%b expected 000/11", {red, green, blue}, out_valid, out_transparent);
    end
    tick();
    tests++;
    if ({red, green, blue, out_valid, out_transparent} !== {12'h777, 1'b1, 1'b0}) begin
      fails++; $display("FAIL opaque_idx7: got %h/%b%b expected 777/10", {red, green, blue}, out_valid, out_transparent);
    end
    tick();
    tests++;
    if ({red, green, blue, out_valid, out_transparent} !== {12'h777, 1'b0, 1'b0}) begin
      fails++; $display("FAIL hold_when_invalid: got %h/%b%b expected 777/00", {red, green, blue}, out_valid, out_transparent);
    end
  endtask

  task automatic test_write_read_first();
    wr_en = 1; wr_bank = 2'd1; wr_index = 4'd5; wr_rgb = 12'hF30;
    in_valid = 1; bank = 2'd1; index = 4'd5;
    tick();
    wr_en = 0;
    tick();
    tests++;
    if ({red, green, blue} !== 12'h555) begin
      fails++; $display("FAIL read_first_old: got %h expected 555", {red, green, blue});
    end
    bank = 2'd0;
    tick();
    tests++;
    if ({red, green, blue} !== 12'hF30) begin
      fails++; $display("FAIL read_after_write: got %h expected f30", {red, green, blue});
    end
    in_valid = 0;
    tick();
    tests++;
    if ({red, green, blue, out_valid} !== {12'h555, 1'b1}) begin
      fails++; $display("FAIL other_bank_intact: got %h/%b expected 555/1", {red, green, blue}, out_valid);
    end
    tick();
  endtask

  task automatic test_fade_out();
    fade_out_req = 1;
    tick();
    fade_out_req = 0;
    tests++;
    if ({fade_level, fade_busy} !== {4'hF, 1'b1}) begin
      fails++; $display("FAIL fade_out_start: got %h/%b expected f/1", fade_level, fade_busy);
    end
    for (int i = 1; i <= 15; i++) begin
      frame_tick = 1;
      tick();
      frame_tick = 0;
      tests++;
      if ({fade_level, fade_busy} !== {4'(15 - i), (i < 15)}) begin
        fails++; $display("FAIL fade_out_step[%0d]: got %h/%b expected %h/%b", i, fade_level, fade_busy, 4'(15 - i), (i < 15));
      end
    end
    frame_tick = 1;
    tick();
    frame_tick = 0;
    in_valid = 1; bank = 2'd1; index = 4'd5;
    tick();
    in_valid = 0;
    tick();
    tests++;
    if ({red, green, blue, out_valid, fade_level, fade_busy} !== {12'h000, 1'b1, 4'h0, 1'b0}) begin
      fails++; $display("FAIL dark_pixel: got %h/%b lvl %h/%b expected 000/1 lvl 0/0", {red, green, blue}, out_valid, fade_level, fade_busy);
    end
  endtask

  task automatic test_fade_reverse();
    fade_in_req = 1;
    tick();
    fade_in_req = 0;
    for (int i = 0; i < 7; i++) begin
      frame_tick = 1; tick(); frame_tick = 0;
    end
    tests++;
    if ({fade_level, fade_busy} !== {4'h7, 1'b1}) begin
      fails++; $display("FAIL fade_in_to7: got %h/%b expected 7/1", fade_level, fade_busy);
    end
    in_valid = 1; bank = 2'd1; index = 4'd5;
    tick();
    in_valid = 0;
    tick();
    tests++;
    if ({red, green, blue} !== 12'h710) begin
      fails++; $display("FAIL level7_pixel: got %h expected 710", {red, green, blue});
    end
    fade_out_req = 1; tick(); fade_out_req = 0;
    frame_tick = 1; tick(); frame_tick = 0;
    tests++;
    if ({fade_level, fade_busy} !== {4'h6, 1'b1}) begin
      fails++; $display("FAIL reverse_to6: got %h/%b expected 6/1", fade_level, fade_busy);
    end
    fade_in_req = 1; fade_out_req = 1; frame_tick = 1;
    tick();
    fade_in_req = 0; fade_out_req = 0; frame_tick = 0;
    tests++;
    if ({fade_level, fade_busy} !== {4'h6, 1'b1}) begin
      fails++; $display("FAIL req_with_tick_holds: got %h/%b expected 6/1", fade_level, fade_busy);
    end
    frame_tick = 1; tick(); frame_tick = 0;
    tests++;
    if (fade_level !== 4'h7) begin
      fails++; $display("FAIL in_after_reverse: got %h expected 7", fade_level);
    end
    for (int i = 0; i < 9; i++) begin
      frame_tick = 1; tick(); frame_tick = 0;
      tests++;
      if (obs !== m_vec()) begin
        fails++; $display("FAIL fade_in_run[%0d]: got %h expected %h", i, obs, m_vec());
      end
    end
    tests++;
    if ({fade_level, fade_busy} !== {4'hF, 1'b0}) begin
      fails++; $display("FAIL full_saturate: got %h/%b expected f/0", fade_level, fade_busy);
    end
  endtask

  task automatic test_reset_midfade();
    fade_out_req = 1; tick(); fade_out_req = 0;
    for (int i = 0; i < 12; i++) begin
      frame_tick = 1; tick(); frame_tick = 0;
    end
    in_valid = 1; bank = 2'd1; index = 4'd5;
    tick();
    tick();
    tests++;
    if (obs !== m_vec() || fade_level !== 4'h3 || out_valid !== 1'b1) begin
      fails++; $display("FAIL pre_reset_lvl3: got %h expected %h", obs, m_vec());
    end
    #2 Reset_n = 0;
    #1;
    tests++;
    if ({fade_level, out_valid, fade_busy} !== {4'hF, 1'b0, 1'b0}) begin
      fails++; $display("FAIL async_reset_now: got lvl %h vld %b busy %b expected f/0/0", fade_level, out_valid, fade_busy);
    end
    model_reset();
    idle_inputs();
    @(negedge Clk);
    Reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs !== m_vec()) begin
        fails++; $display("FAIL flushed[%0d]: got %h expected %h", i, obs, m_vec());
      end
    end
    in_valid = 1; bank = 2'd1; index = 4'd5;
    tick();
    in_valid = 0;
    tick();
    tests++;
    if ({red, green, blue, out_valid} !== {12'h555, 1'b1}) begin
      fails++; $display("FAIL palette_reverted: got %h/%b expected 555/1", {red, green, blue}, out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid     = 1'($urandom_range(0, 1));
      bank         = 2'($urandom);
      index        = 4'($urandom);
      wr_en        = ($urandom_range(0, 3) == 0);
      wr_bank      = 2'($urandom);
      wr_index     = 4'($urandom);
      wr_rgb       = 12'($urandom);
      frame_tick   = ($urandom_range(0, 2) == 0);
      fade_out_req = ($urandom_range(0, 11) == 0);
      fade_in_req  = ($urandom_range(0, 11) == 0);
      tick();
      tests++;
      if (obs !== m_vec()) begin
        fails++; $display("FAIL random[%0d]: got %h expected %h", i, obs, m_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_grey();
    test_transparent();
    test_write_read_first();
    test_fade_out();
    test_fade_reverse();
    test_reset_midfade();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
